// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - op codes, state encoding and decode helpers for muldiv_unit
package muldiv_unit_pkg;

   localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
   localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
   localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX,
      ST_DONE
   } state_t;

   function automatic logic is_md(input logic [7:0] op);
      return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
             (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
   endfunction

   function automatic logic is_signed_op(input logic [7:0] op);
      return (op == EXE_MULT_OP) || (op == EXE_DIV_OP);
   endfunction

   function automatic logic is_div_op(input logic [7:0] op);
      return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
   endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// rtl/muldiv_unit_div_core.sv - registered radix-2 restoring divider on unsigned magnitudes
module muldiv_unit_div_core #(
   parameter int WIDTH    = 32,
   parameter int DIV_ITER = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             cancel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             done
);

   localparam int CW = $clog2(DIV_ITER);

   logic [CW-1:0]    cnt;
   logic             busy;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             fits;

   // Unsigned compare keeps divide-by-zero well defined: every step subtracts, giving all-ones quotient
   assign shifted = {remainder, quotient[WIDTH-1]};
   assign diff    = shifted - {1'b0, divisor};
   assign fits    = (shifted >= {1'b0, divisor});
   assign done    = busy && (cnt == CW'(DIV_ITER - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt       <= '0;
         busy      <= 1'b0;
         divisor   <= '0;
         quotient  <= '0;
         remainder <= '0;
      end else if (cancel) begin
         busy <= 1'b0;
      end else if (start) begin
         cnt       <= '0;
         busy      <= 1'b1;
         divisor   <= b;
         quotient  <= a;
         remainder <= '0;
      end else if (busy) begin
         if (fits) begin
            remainder <= diff[WIDTH-1:0];
            quotient  <= {quotient[WIDTH-2:0], 1'b1};
         end else begin
            remainder <= shifted[WIDTH-1:0];
            quotient  <= {quotient[WIDTH-2:0], 1'b0};
         end
         cnt <= cnt + 1'b1;
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - execute-stage HI/LO multiply/divide engine with pipeline stall handshake
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int DIV_ITER = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [7:0]       alucontrolE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   input  logic             flushE,
   input  logic             holdE,
   output logic             stall_o,
   output logic             ready_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   state_t             state;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic               sgn;
   logic               start;
   logic               in_signed;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic               div_done;
   logic [2*WIDTH-1:0] ext_a;
   logic [2*WIDTH-1:0] ext_b;
   logic [2*WIDTH-1:0] product;
   logic               neg_q;
   logic               neg_r;

   assign start     = resetn && (state == ST_IDLE) && is_md(alucontrolE) && !flushE;
   assign stall_o   = start || (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIX);
   assign in_signed = is_signed_op(alucontrolE);
   assign mag_a     = (in_signed && srcaE[WIDTH-1]) ? -srcaE : srcaE;
   assign mag_b     = (in_signed && srcbE[WIDTH-1]) ? -srcbE : srcbE;

   // Widening to 2*WIDTH first makes one multiplier serve both signed and unsigned forms
   assign ext_a   = sgn ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
   assign ext_b   = sgn ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
   assign product = ext_a * ext_b;

   assign neg_q = sgn && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
   assign neg_r = sgn && op_a[WIDTH-1];

   muldiv_unit_div_core #(
      .WIDTH    (WIDTH),
      .DIV_ITER (DIV_ITER)
   ) u_div_core (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start && is_div_op(alucontrolE)),
      .cancel    (flushE),
      .a         (mag_a),
      .b         (mag_b),
      .quotient  (quo),
      .remainder (rem),
      .done      (div_done)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= ST_IDLE;
         op_a    <= '0;
         op_b    <= '0;
         sgn     <= 1'b0;
         ready_o <= 1'b0;
         hi_o    <= '0;
         lo_o    <= '0;
      end else if (flushE) begin
         state   <= ST_IDLE;
         ready_o <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_a  <= srcaE;
                  op_b  <= srcbE;
                  sgn   <= in_signed;
                  state <= is_div_op(alucontrolE) ? ST_DIV : ST_MUL;
               end
            end
            ST_MUL: begin
               hi_o    <= product[2*WIDTH-1:WIDTH];
               lo_o    <= product[WIDTH-1:0];
               ready_o <= 1'b1;
               state   <= ST_DONE;
            end
            ST_DIV: begin
               if (div_done) state <= ST_FIX;
            end
            ST_FIX: begin
               hi_o    <= neg_r ? -rem : rem;
               lo_o    <= neg_q ? -quo : quo;
               ready_o <= 1'b1;
               state   <= ST_DONE;
            end
            ST_DONE: begin
               if (!holdE) begin
                  ready_o <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            default: begin
               ready_o <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed table-driven bench for muldiv_unit
module tb_muldiv_unit;

   localparam logic [7:0] OP_MULT  = 8'h18;
   localparam logic [7:0] OP_MULTU = 8'h19;
   localparam logic [7:0] OP_DIV   = 8'h1A;
   localparam logic [7:0] OP_DIVU  = 8'h1B;
   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_ADD   = 8'h20;
   localparam int NV = 11;

   typedef struct {
      string       name;
      logic [7:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [7:0]  alucontrolE = OP_NOP;
   logic [31:0] srcaE = '0;
   logic [31:0] srcbE = '0;
   logic        flushE = 1'b0;
   logic        holdE = 1'b0;
   logic        stall_o;
   logic        ready_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int n_cmp = 0;
   int n_bad = 0;
   vec_t vecs[NV];

   muldiv_unit #(.WIDTH(32), .DIV_ITER(32)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .alucontrolE (alucontrolE),
      .srcaE       (srcaE),
      .srcbE       (srcbE),
      .flushE      (flushE),
      .holdE       (holdE),
      .stall_o     (stall_o),
      .ready_o     (ready_o),
      .hi_o        (hi_o),
      .lo_o        (lo_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called with inputs already driven in cycle 0; returns at the negedge of the first ready cycle.
   task automatic wait_ready(output int cyc, output int stalls, output bit got);
      cyc = 0;
      stalls = 0;
      got = 1'b0;
      while (!got && cyc < 60) begin
         @(negedge clk);
         if (ready_o) got = 1'b1;
         else begin
            if (stall_o) stalls++;
            cyc++;
            @(posedge clk);
            #1;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  cyc;
      int  stalls;
      bit  got;
      bit  seen;
      logic [31:0] keep_hi;
      logic [31:0] keep_lo;

      vecs[0]  = '{"multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2};
      vecs[1]  = '{"mult_m3x7",  OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 2};
      vecs[2]  = '{"mult_minsq", OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 2};
      vecs[3]  = '{"multu_x16",  OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 2};
      vecs[4]  = '{"div_m7_2",   OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34};
      vecs[5]  = '{"divu_7_2",   OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 34};
      vecs[6]  = '{"divu_5_0",   OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 34};
      vecs[7]  = '{"div_min_m1", OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34};
      vecs[8]  = '{"div_7_m2",   OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34};
      vecs[9]  = '{"div_m5_0",   OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'h00000001, 34};
      vecs[10] = '{"divu_max_7", OP_DIVU,  32'hFFFFFFFF, 32'h00000007, 32'h00000003, 32'h24924924, 34};

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_hi", hi_o, 32'h0);
      check("reset_lo", lo_o, 32'h0);
      check("reset_ready", 32'(ready_o), 32'h0);
      check("reset_stall", 32'(stall_o), 32'h0);
      @(posedge clk);
      #1 resetn = 1'b1;

      // Non-MD op in IDLE must not stall or start anything
      alucontrolE = OP_ADD;
      srcaE = 32'd9;
      srcbE = 32'd4;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (stall_o || ready_o) seen = 1'b1;
      end
      check("non_md_idle", 32'(seen), 32'h0);
      @(posedge clk);
      #1;

      // Consecutive vectors are issued back-to-back: the next op appears as DONE is left
      for (int i = 0; i < NV; i++) begin
         alucontrolE = vecs[i].op;
         srcaE = vecs[i].a;
         srcbE = vecs[i].b;
         wait_ready(cyc, stalls, got);
         check({vecs[i].name, "_ready"}, 32'(got), 32'h1);
         check({vecs[i].name, "_latency"}, 32'(cyc), 32'(vecs[i].lat));
         check({vecs[i].name, "_stall_cycles"}, 32'(stalls), 32'(vecs[i].lat));
         check({vecs[i].name, "_stall_done"}, 32'(stall_o), 32'h0);
         check({vecs[i].name, "_hi"}, hi_o, vecs[i].hi);
         check({vecs[i].name, "_lo"}, lo_o, vecs[i].lo);
         @(posedge clk);
         #1;
      end
      alucontrolE = OP_NOP;
      keep_hi = vecs[NV-1].hi;
      keep_lo = vecs[NV-1].lo;

      // Flush in the 10th division iteration
      @(posedge clk);
      #1;
      alucontrolE = OP_DIVU;
      srcaE = 32'd100;
      srcbE = 32'd3;
      @(negedge clk);
      check("flush_div_start_stall", 32'(stall_o), 32'h1);
      repeat (11) @(posedge clk);
      #1 flushE = 1'b1;
      @(negedge clk);
      check("flush_div_busy_stall", 32'(stall_o), 32'h1);
      @(posedge clk);
      #1;
      flushE = 1'b0;
      alucontrolE = OP_NOP;
      @(negedge clk);
      check("flush_div_stall", 32'(stall_o), 32'h0);
      check("flush_div_ready", 32'(ready_o), 32'h0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (ready_o || stall_o) seen = 1'b1;
      end
      check("flush_div_no_ready", 32'(seen), 32'h0);
      check("flush_div_hi", hi_o, keep_hi);
      check("flush_div_lo", lo_o, keep_lo);

      // Flush in the same cycle as a would-be start
      @(posedge clk);
      #1;
      alucontrolE = OP_MULT;
      srcaE = 32'd3;
      srcbE = 32'd7;
      flushE = 1'b1;
      @(negedge clk);
      check("flush_start_stall", 32'(stall_o), 32'h0);
      @(posedge clk);
      #1;
      flushE = 1'b0;
      alucontrolE = OP_NOP;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (ready_o || stall_o) seen = 1'b1;
      end
      check("flush_start_idle", 32'(seen), 32'h0);
      check("flush_start_lo", lo_o, keep_lo);

      // Hold in DONE for three cycles with the instruction still present
      @(posedge clk);
      #1;
      alucontrolE = OP_MULTU;
      srcaE = 32'd3;
      srcbE = 32'd5;
      wait_ready(cyc, stalls, got);
      check("hold_first_ready", 32'(got), 32'h1);
      holdE = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("hold_ready_%0d", k), 32'(ready_o), 32'h1);
         check($sformatf("hold_stall_%0d", k), 32'(stall_o), 32'h0);
         check($sformatf("hold_lo_%0d", k), lo_o, 32'd15);
      end
      holdE = 1'b0;
      @(posedge clk);
      #1 alucontrolE = OP_NOP;
      @(negedge clk);
      check("hold_release_ready", 32'(ready_o), 32'h0);
      check("hold_release_stall", 32'(stall_o), 32'h0);
      check("hold_release_lo", lo_o, 32'd15);

      // Asynchronous reset in the middle of a division
      @(posedge clk);
      #1;
      alucontrolE = OP_DIV;
      srcaE = 32'hFFFFFFF9;
      srcbE = 32'd2;
      repeat (5) @(posedge clk);
      #3 resetn = 1'b0;
      #1;
      check("arst_hi", hi_o, 32'h0);
      check("arst_lo", lo_o, 32'h0);
      check("arst_ready", 32'(ready_o), 32'h0);
      check("arst_stall", 32'(stall_o), 32'h0);
      alucontrolE = OP_NOP;
      @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      check("arst_after_stall", 32'(stall_o), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
